// File: rtl/button_event_decoder_if.sv
// button_event_decoder_if: enable/level inputs and event outputs of one button decoder.
interface button_event_decoder_if;
  logic enable;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;
  modport master (
    output enable, btn_level,
    input  press_pulse, release_pulse, click_pulse, double_pulse, long_pulse, repeat_pulse, held
  );
  modport slave (
    input  enable, btn_level,
    output press_pulse, release_pulse, click_pulse, double_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/click/double/long/repeat pulses.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int DCLICK_CYCLES = 300,
  parameter int CNT_W         = 16
) (
  input logic clk,
  input logic reset,
  button_event_decoder_if.slave bus
);
  typedef enum logic [2:0] {WAIT_REL, IDLE, PRESSED, REPEAT, WAIT_DC} state_t;
  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DC_T   = CNT_W'(DCLICK_CYCLES - 1);
  state_t r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic r_sync, r_lvl, r_second, w_second;
  logic [1:0] r_prime;
  logic r_press, r_release, r_click, r_double, r_long, r_repeat, r_held;
  logic w_press, w_release, w_click, w_double, w_long, w_repeat;
  // r_prime holds WAIT_REL until the synchronizer carries a real sample,
  // so a button held through reset is not mistaken for a release.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sync  <= 1'b0;
      r_lvl   <= 1'b0;
      r_prime <= 2'b00;
    end else begin
      r_sync  <= bus.btn_level;
      r_lvl   <= r_sync;
      r_prime <= {r_prime[0], 1'b1};
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= WAIT_REL;
      r_cnt     <= '0;
      r_second  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_second  <= w_second;
      r_press   <= w_press;
      r_release <= w_release;
      r_click   <= w_click;
      r_double  <= w_double;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
      r_held    <= w_state == PRESSED || w_state == REPEAT;
    end
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_second  = r_second;
    w_press   = 1'b0;
    w_release = 1'b0;
    w_click   = 1'b0;
    w_double  = 1'b0;
    w_long    = 1'b0;
    w_repeat  = 1'b0;
    if (!bus.enable) begin
      w_state  = WAIT_REL;
      w_cnt    = '0;
      w_second = 1'b0;
    end else begin
      case (r_state)
        WAIT_REL: w_state = r_prime[1] && !r_lvl ? IDLE : WAIT_REL;
        IDLE:
          if (r_lvl) begin
            w_state  = PRESSED;
            w_press  = 1'b1;
            w_cnt    = '0;
            w_second = 1'b0;
          end
        PRESSED:
          if (!r_lvl) begin
            w_release = 1'b1;
            w_state   = r_second ? IDLE : WAIT_DC;
            w_cnt     = '0;
          end else if (r_cnt == LONG_T) begin
            w_long  = 1'b1;
            w_state = REPEAT;
            w_cnt   = '0;
          end else
            w_cnt = r_cnt + 1'b1;
        REPEAT:
          if (!r_lvl) begin
            w_release = 1'b1;
            w_state   = IDLE;
            w_cnt     = '0;
          end else if (r_cnt == REP_T) begin
            w_repeat = 1'b1;
            w_cnt    = '0;
          end else
            w_cnt = r_cnt + 1'b1;
        WAIT_DC:
          if (r_lvl) begin
            w_press  = 1'b1;
            w_double = 1'b1;
            w_state  = PRESSED;
            w_second = 1'b1;
            w_cnt    = '0;
          end else if (r_cnt == DC_T) begin
            w_click = 1'b1;
            w_state = IDLE;
            w_cnt   = '0;
          end else
            w_cnt = r_cnt + 1'b1;
        default: w_state = WAIT_REL;
      endcase
    end
  end
  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.click_pulse   = r_click;
  assign bus.double_pulse  = r_double;
  assign bus.long_pulse    = r_long;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.held          = r_held;
endmodule
